// File: rtl/lstm_delta_seq.sv
// lstm_delta_seq: LSTM backprop delta unit; a 16-step sequencer time-shares one multiplier and one adder per cell.
module lstm_delta_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC = 24,
  parameter int CELLS = 16,
  localparam int IW = (CELLS > 1) ? $clog2(CELLS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [IW-1:0]    in_idx,
  input  logic [WIDTH-1:0] at,
  input  logic [WIDTH-1:0] it,
  input  logic [WIDTH-1:0] ft,
  input  logic [WIDTH-1:0] ot,
  input  logic [WIDTH-1:0] tanh_c,
  input  logic [WIDTH-1:0] c_prev,
  input  logic [WIDTH-1:0] d_out,
  input  logic [WIDTH-1:0] d_state_next,
  input  logic [WIDTH-1:0] f_next,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IW-1:0]    out_idx,
  output logic [WIDTH-1:0] o_d_state,
  output logic [WIDTH-1:0] o_dat,
  output logic [WIDTH-1:0] o_dit,
  output logic [WIDTH-1:0] o_dft,
  output logic [WIDTH-1:0] o_dot,
  output logic             o_sat
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC;
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  state_t state, state_nx;
  logic [3:0] step;
  logic [WIDTH-1:0] at_r, it_r, ft_r, ot_r, th_r, cp_r, do_r, dsn_r, fn_r, t0, t1;
  logic [WIDTH-1:0] mul_a, mul_bx, mul_b, sub_x, mul_r, sub_r, add_r;
  logic signed [2*WIDTH-1:0] prod, prod_sh;
  logic [WIDTH:0] sub_f, add_f;
  logic last_r, accept, use_sub, mul_ovf, sub_ovf, add_ovf, sat_step;
  assign in_ready = rst && (state == IDLE || (state == DONE && out_ready));
  assign accept = in_valid && in_ready;
  assign out_valid = state == DONE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    state_nx = accept ? BUSY :
               (state == BUSY && step == 4'd15) ? DONE :
               (state == DONE && out_ready) ? IDLE : state;
  end
  // Operand routing for the shared multiplier; (ONE - x) feeds its second input when used.
  always_comb begin
    mul_a = '0;
    mul_bx = '0;
    case (step)
      4'd0: begin mul_a = th_r; mul_bx = th_r; end
      4'd1: begin mul_a = do_r; mul_bx = ot_r; end
      4'd2: mul_a = t1;
      4'd3: begin mul_a = dsn_r; mul_bx = fn_r; end
      4'd4: mul_a = ot_r;
      4'd5: begin mul_a = t0; mul_bx = th_r; end
      4'd6: begin mul_a = t0; mul_bx = do_r; end
      4'd7: begin mul_a = at_r; mul_bx = at_r; end
      4'd8: begin mul_a = o_d_state; mul_bx = it_r; end
      4'd9: mul_a = t1;
      4'd10: mul_a = it_r;
      4'd11: begin mul_a = t0; mul_bx = at_r; end
      4'd12: begin mul_a = t0; mul_bx = o_d_state; end
      4'd13: mul_a = ft_r;
      4'd14: begin mul_a = t0; mul_bx = cp_r; end
      default: begin mul_a = t0; mul_bx = o_d_state; end
    endcase
  end
  assign use_sub = step == 4'd2 || step == 4'd4 || step == 4'd9 || step == 4'd10 || step == 4'd13;
  assign sub_x = (step == 4'd2 || step == 4'd9) ? t0 : step == 4'd4 ? ot_r : step == 4'd10 ? it_r : ft_r;
  assign sub_f = {1'b0, ONE} - {sub_x[WIDTH-1], sub_x};
  assign sub_ovf = sub_f[WIDTH] != sub_f[WIDTH-1];
  assign sub_r = sub_ovf ? (sub_f[WIDTH] ? MINV : MAXV) : sub_f[WIDTH-1:0];
  assign mul_b = use_sub ? sub_r : mul_bx;
  assign prod = $signed({{WIDTH{mul_a[WIDTH-1]}}, mul_a}) * $signed({{WIDTH{mul_b[WIDTH-1]}}, mul_b});
  assign prod_sh = prod >>> FRAC;
  assign mul_ovf = !((&prod_sh[2*WIDTH-1:WIDTH-1]) || !(|prod_sh[2*WIDTH-1:WIDTH-1]));
  assign mul_r = mul_ovf ? (prod_sh[2*WIDTH-1] ? MINV : MAXV) : prod_sh[WIDTH-1:0];
  assign add_f = {t0[WIDTH-1], t0} + {t1[WIDTH-1], t1};
  assign add_ovf = add_f[WIDTH] != add_f[WIDTH-1];
  assign add_r = add_ovf ? (add_f[WIDTH] ? MINV : MAXV) : add_f[WIDTH-1:0];
  // The skipped product at step 3 in last-timestep mode must not flag saturation.
  assign sat_step = (mul_ovf && !(step == 4'd3 && last_r)) || (sub_ovf && use_sub) || (add_ovf && step == 4'd4);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {at_r, it_r, ft_r, ot_r, th_r, cp_r, do_r, dsn_r, fn_r, t0, t1} <= '0;
      {o_d_state, o_dat, o_dit, o_dft, o_dot} <= '0;
      last_r <= 1'b0;
      out_idx <= '0;
      step <= '0;
      o_sat <= 1'b0;
    end else if (accept) begin
      {at_r, it_r, ft_r, ot_r, th_r} <= {at, it, ft, ot, tanh_c};
      {cp_r, do_r, dsn_r, fn_r} <= {c_prev, d_out, d_state_next, f_next};
      last_r <= in_last;
      out_idx <= in_idx;
      step <= '0;
      o_sat <= 1'b0;
    end else if (state == BUSY) begin
      step <= step + 4'd1;
      o_sat <= o_sat | sat_step;
      case (step)
        4'd1, 4'd8: t1 <= mul_r;
        4'd3: t1 <= last_r ? '0 : mul_r;
        4'd4: begin o_d_state <= add_r; t0 <= mul_r; end
        4'd6: o_dot <= mul_r;
        4'd9: o_dat <= mul_r;
        4'd12: o_dit <= mul_r;
        4'd15: o_dft <= mul_r;
        default: t0 <= mul_r;
      endcase
    end
  end
endmodule

// File: tb/tb_lstm_delta_seq.sv
// tb_lstm_delta_seq: directed scoreboard bench for lstm_delta_seq against a Q8.24 reference model.
module tb_lstm_delta_seq;
  localparam logic [31:0] ONE = 32'h01000000;
  localparam logic [31:0] HALF = 32'h00800000;
  typedef struct {
    logic [31:0] at, it, ft, ot, th, cp, dout, dsn, fn;
    logic last;
    logic [3:0] idx;
  } ops_t;
  typedef struct {
    logic [3:0] idx;
    logic [31:0] ds, dot, dat, dit, dft;
    logic sat;
  } res_t;
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, o_sat;
  logic [3:0] in_idx = '0, out_idx;
  logic [31:0] at = '0, it = '0, ft = '0, ot = '0, tanh_c = '0, c_prev = '0;
  logic [31:0] d_out = '0, d_state_next = '0, f_next = '0;
  logic [31:0] o_d_state, o_dat, o_dit, o_dft, o_dot;
  int vectors = 0, errs = 0;
  logic msat;
  res_t sb[$];
  always #5 clk = ~clk;
  lstm_delta_seq #(.WIDTH(32), .FRAC(24), .CELLS(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_idx(in_idx), .at(at), .it(it), .ft(ft), .ot(ot), .tanh_c(tanh_c), .c_prev(c_prev),
    .d_out(d_out), .d_state_next(d_state_next), .f_next(f_next), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .o_d_state(o_d_state), .o_dat(o_dat),
    .o_dit(o_dit), .o_dft(o_dft), .o_dot(o_dot), .o_sat(o_sat)
  );
  function automatic logic [31:0] satq(input longint v);
    if (v > 64'sd2147483647) begin msat = 1'b1; return 32'h7FFFFFFF; end
    if (v < -64'sd2147483648) begin msat = 1'b1; return 32'h80000000; end
    return v[31:0];
  endfunction
  function automatic logic [31:0] mulq(input logic [31:0] a, input logic [31:0] b);
    return satq((longint'($signed(a)) * longint'($signed(b))) >>> 24);
  endfunction
  function automatic logic [31:0] subq(input logic [31:0] x);
    return satq(longint'($signed(ONE)) - longint'($signed(x)));
  endfunction
  function automatic logic [31:0] addq(input logic [31:0] a, input logic [31:0] b);
    return satq(longint'($signed(a)) + longint'($signed(b)));
  endfunction
  function automatic res_t model(input ops_t o);
    res_t r;
    logic [31:0] nxt;
    msat = 1'b0;
    r.idx = o.idx;
    nxt = o.last ? 32'h0 : mulq(o.dsn, o.fn);
    r.ds = addq(mulq(mulq(o.dout, o.ot), subq(mulq(o.th, o.th))), nxt);
    r.dot = mulq(mulq(mulq(o.ot, subq(o.ot)), o.th), o.dout);
    r.dat = mulq(mulq(r.ds, o.it), subq(mulq(o.at, o.at)));
    r.dit = mulq(mulq(mulq(o.it, subq(o.it)), o.at), r.ds);
    r.dft = mulq(mulq(mulq(o.ft, subq(o.ft)), o.cp), r.ds);
    r.sat = msat;
    return r;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic send(input ops_t o);
    int n;
    n = 0;
    {at, it, ft, ot, tanh_c, c_prev} = {o.at, o.it, o.ft, o.ot, o.th, o.cp};
    {d_out, d_state_next, f_next, in_last, in_idx} = {o.dout, o.dsn, o.fn, o.last, o.idx};
    sb.push_back(model(o));
    in_valid = 1'b1;
    while (!in_ready && n < 64) begin @(negedge clk); n++; end
    chk("in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
  endtask
  task automatic receive();
    int n;
    res_t e;
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    chk("latency", n, 32'd16);
    if (sb.size() == 0) begin
      errs++;
      $error("FAIL scoreboard: observed empty queue expected pending result");
      return;
    end
    e = sb.pop_front();
    chk("out_idx", 32'(out_idx), 32'(e.idx));
    chk("d_state", o_d_state, e.ds);
    chk("dot", o_dot, e.dot);
    chk("dat", o_dat, e.dat);
    chk("dit", o_dit, e.dit);
    chk("dft", o_dft, e.dft);
    chk("sat", 32'(o_sat), 32'(e.sat));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    ops_t base, o;
    logic [31:0] cap_ds, cap_dit;
    logic [3:0] cap_idx;
    base = '{at: HALF, it: HALF, ft: HALF, ot: HALF, th: HALF, cp: ONE, dout: ONE,
             dsn: 32'h0, fn: 32'h0, last: 1'b1, idx: 4'd1};
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_d_state", o_d_state, 32'd0);
    chk("rst_sat", 32'(o_sat), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    send(base);
    receive();
    chk("t1_ds", o_d_state, 32'h00600000);
    chk("t1_dot", o_dot, 32'h00200000);
    chk("t1_dat", o_dat, 32'h00240000);
    chk("t1_dit", o_dit, 32'h000C0000);
    chk("t1_dft", o_dft, 32'h00180000);
    chk("t1_sat", 32'(o_sat), 32'd0);
    @(negedge clk);
    o = base; o.last = 1'b0; o.dsn = ONE; o.fn = HALF; o.idx = 4'd2;
    send(o);
    receive();
    chk("t2_ds", o_d_state, 32'h00E00000);
    chk("t2_dat", o_dat, 32'h00540000);
    chk("t2_dit", o_dit, 32'h001C0000);
    chk("t2_dft", o_dft, 32'h00380000);
    chk("t2_dot", o_dot, 32'h00200000);
    @(negedge clk);
    o = base; o.dout = 32'h7FFFFFFF; o.ot = ONE; o.th = 32'h0;
    o.dsn = 32'h7FFFFFFF; o.fn = ONE; o.last = 1'b0; o.idx = 4'd5;
    send(o);
    receive();
    chk("t3_ds", o_d_state, 32'h7FFFFFFF);
    chk("t3_sat", 32'(o_sat), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
    o = base; o.last = 1'b0; o.dsn = ONE; o.fn = HALF; o.idx = 4'd6;
    send(o);
    receive();
    cap_ds = o_d_state; cap_dit = o_dit; cap_idx = out_idx;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_ds", o_d_state, cap_ds);
      chk("hold_dit", o_dit, cap_dit);
      chk("hold_idx", 32'(out_idx), 32'(cap_idx));
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("same_edge_ready", 32'(in_ready), 32'd1);
    o = base; o.idx = 4'd3;
    send(o);
    receive();
    chk("t4_idx", 32'(out_idx), 32'd3);
    @(negedge clk);
    o = base; o.idx = 4'd7;
    send(o);
    repeat (7) @(negedge clk);
    rst = 1'b0;
    sb.delete(sb.size() - 1);
    #1;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd0);
    chk("t5_ds", o_d_state, 32'd0);
    chk("t5_dot", o_dot, 32'd0);
    chk("t5_dft", o_dft, 32'd0);
    chk("t5_idx", 32'(out_idx), 32'd0);
    chk("t5_sat", 32'(o_sat), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(o);
    receive();
    chk("t5_rerun_ds", o_d_state, 32'h00600000);
    chk("t5_rerun_dat", o_dat, 32'h00240000);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (i == 0) begin
        o = base; o.dout = 32'hFFFFFFFF;
      end else begin
        o.at = $urandom_range(0, 32'h01000000);
        o.it = $urandom_range(0, 32'h01000000);
        o.ft = $urandom_range(0, 32'h01000000);
        o.ot = $urandom_range(0, 32'h01000000);
        o.th = $urandom_range(0, 32'h02000000) - ONE;
        o.cp = (i % 4 == 0) ? $urandom() : $urandom_range(0, 32'h04000000);
        o.dout = (i % 5 == 0) ? $urandom() : $urandom_range(0, 32'h02000000);
        o.dsn = (i % 3 == 0) ? $urandom() : $urandom_range(0, 32'h02000000);
        o.fn = $urandom_range(0, 32'h01000000);
        o.last = i[0];
      end
      o.idx = i[3:0];
      send(o);
      receive();
      if (i == 0) chk("t6_dot_floor", o_dot, 32'hFFFFFFFF);
    end
    repeat (2) @(negedge clk);
    chk("end_valid", 32'(out_valid), 32'd0);
    chk("end_in_ready", 32'(in_ready), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
